r_handler_fwft: RTL and testbench

Read-side pointer handler for the asynchronous FIFO, and the counterpart of the write-side handler. It owns the binary/Gray read pointer, derives empty and fill level from the synchronized Gray write pointer, and issues reads to the synchronous-read dual-port memory. It presents data to the consumer as first-word-fall-through over a valid/ready handshake, using a 2-entry output buffer so it sustains one word per clock.

---
 rtl/r_handler_fwft_pkg.sv | 15 +
 rtl/r_handler_fwft_if.sv | 11 +
 rtl/b2g.sv | 9 +
 rtl/g2b.sv | 14 +
 rtl/r_handler_fwft_out_buf2.sv | 63 ++++++
 rtl/r_handler_fwft.sv | 68 ++++++
 tb/tb_r_handler_fwft.sv | 222 ++++++++++++++++++++++
 7 files changed

// File: rtl/r_handler_fwft_pkg.sv
// Shared definitions for the async FIFO read-side pointer handler.
package r_handler_fwft_pkg;

  localparam int PTR_WIDTH_DEF  = 4;
  localparam int DATA_WIDTH_DEF = 8;
  localparam int AE_THRESH_DEF  = 1;
  localparam int GRAY_MAX_W     = 32;

  // Gray pointers are equal only when every bit, including the wrap MSB, matches.
  function automatic logic gray_eq(input logic [GRAY_MAX_W-1:0] a,
                                   input logic [GRAY_MAX_W-1:0] b);
    return a == b;
  endfunction

endpackage

// File: rtl/r_handler_fwft_if.sv
// Consumer-side first-word-fall-through valid/ready stream.
interface r_handler_fwft_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  rd_valid;
  logic                  rd_ready;
  logic [DATA_WIDTH-1:0] rd_data;

  modport master (output rd_valid, output rd_data, input rd_ready);
  modport slave  (input rd_valid, input rd_data, output rd_ready);
endinterface

// File: rtl/b2g.sv
// Binary to Gray code converter.
module b2g #(
  parameter int W = 4
) (
  input  logic [W-1:0] bin,
  output logic [W-1:0] gray
);
  assign gray = bin ^ (bin >> 1);
endmodule

// File: rtl/g2b.sv
// Gray to binary code converter: each binary bit is the XOR of all Gray bits at or above it.
module g2b #(
  parameter int W = 4
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);
  always_comb begin
    bin = '0;
    for (int i = 0; i < W; i++) begin
      bin[i] = ^(gray >> i);
    end
  end
endmodule

// File: rtl/r_handler_fwft_out_buf2.sv
// Two-entry FIFO-ordered output buffer; head is presented combinationally on dout.
module out_buf2 #(
  parameter int W = 8
) (
  input  logic         rclk,
  input  logic         rrst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [1:0]   cnt
);
  logic [W-1:0] head, tail, head_next;
  logic [1:0]   cnt_next;
  logic         load_tail;

  // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    cnt_next  = cnt;
    head_next = head;
    load_tail = 1'b0;
    case ({push, pop})
      2'b10: begin
        cnt_next = 2'(cnt + 2'd1);
        if (cnt == 2'd0) head_next = din;
        else             load_tail = 1'b1;
      end
      2'b01: begin
        cnt_next = 2'(cnt - 2'd1);
        if (cnt == 2'd2) head_next = tail;
      end
      2'b11: begin
        if (cnt == 2'd1) begin
          head_next = din;
        end else begin
          head_next = tail;
          load_tail = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      cnt  <= 2'd0;
      head <= '0;
    end else begin
      cnt  <= cnt_next;
      head <= head_next;
    end
  end

  // NOTE: the tail entry is pure storage gated by cnt, so it carries no reset.
  always_ff @(posedge rclk) begin
    if (load_tail) tail <= din;
  end

  assign dout = head;

  a_cnt_max:   assert property (@(posedge rclk) disable iff (rrst) cnt <= 2'd2);
  a_no_ovfl:   assert property (@(posedge rclk) disable iff (rrst) !(push && !pop && cnt == 2'd2));
endmodule

// File: rtl/r_handler_fwft.sv
// Read-side pointer handler: Gray/binary read pointer, empty/level, FWFT output over valid/ready.
module r_handler_fwft
  import r_handler_fwft_pkg::*;
#(
  parameter int PTR_WIDTH  = PTR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int AE_THRESH  = AE_THRESH_DEF
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic [PTR_WIDTH-1:0]  g_wptr_sync,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_ren,
  output logic [PTR_WIDTH-2:0]  mem_raddr,
  output logic [PTR_WIDTH-1:0]  b_rptr,
  output logic [PTR_WIDTH-1:0]  g_rptr,
  output logic                  ptr_empty,
  output logic [PTR_WIDTH-1:0]  rd_level,
  output logic                  almost_empty,
  r_handler_fwft_if.master      rd
);
  logic [PTR_WIDTH-1:0] b_wptr_sync, b_rptr_next, g_rptr_next, level_next;
  logic                 in_flight, pop;
  logic [1:0]           buf_cnt;
  logic [2:0]           occ;

  g2b #(.W(PTR_WIDTH)) u_g2b (.gray(g_wptr_sync), .bin(b_wptr_sync));
  b2g #(.W(PTR_WIDTH)) u_b2g (.bin(b_rptr_next), .gray(g_rptr_next));

  assign pop       = rd.rd_valid & rd.rd_ready;
  assign ptr_empty = gray_eq(GRAY_MAX_W'(g_rptr), GRAY_MAX_W'(g_wptr_sync));

  // Words already owned by the buffer after this cycle's pop; fetch only while a slot is free.
  assign occ         = 3'(buf_cnt) + 3'(in_flight) - 3'(pop);
  assign mem_ren     = !rrst && !ptr_empty && (occ < 3'd2);
  assign mem_raddr   = b_rptr[PTR_WIDTH-2:0];
  assign b_rptr_next = b_rptr + PTR_WIDTH'(mem_ren);

  assign level_next   = (b_wptr_sync - b_rptr) + PTR_WIDTH'(in_flight) + PTR_WIDTH'(buf_cnt);
  assign almost_empty = (rd_level <= PTR_WIDTH'(AE_THRESH));

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      b_rptr    <= '0;
      g_rptr    <= '0;
      in_flight <= 1'b0;
      rd_level  <= '0;
    end else begin
      b_rptr    <= b_rptr_next;
      g_rptr    <= g_rptr_next;
      in_flight <= mem_ren;
      rd_level  <= level_next;
    end
  end

  out_buf2 #(.W(DATA_WIDTH)) u_buf (
    .rclk (rclk),
    .rrst (rrst),
    .push (in_flight),
    .pop  (pop),
    .din  (mem_rdata),
    .dout (rd.rd_data),
    .cnt  (buf_cnt)
  );

  assign rd.rd_valid = (buf_cnt != 2'd0);
endmodule

// File: tb/tb_r_handler_fwft.sv
// Self-checking bench for r_handler_fwft: directed scenarios plus randomized traffic vs a queue model.
module tb_r_handler_fwft;
  localparam int PW    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int AE    = 1;

  logic          rclk = 1'b0;
  logic          rrst = 1'b1;
  logic [PW-1:0] g_wptr_sync = '0;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ren;
  logic [PW-2:0] mem_raddr;
  logic [PW-1:0] b_rptr, g_rptr, rd_level;
  logic          ptr_empty, almost_empty;

  r_handler_fwft_if #(.DATA_WIDTH(DW)) rd ();

  r_handler_fwft #(.PTR_WIDTH(PW), .DATA_WIDTH(DW), .AE_THRESH(AE)) dut (
    .rclk         (rclk),
    .rrst         (rrst),
    .g_wptr_sync  (g_wptr_sync),
    .mem_rdata    (mem_rdata),
    .mem_ren      (mem_ren),
    .mem_raddr    (mem_raddr),
    .b_rptr       (b_rptr),
    .g_rptr       (g_rptr),
    .ptr_empty    (ptr_empty),
    .rd_level     (rd_level),
    .almost_empty (almost_empty),
    .rd           (rd.master)
  );

  always #5 rclk = ~rclk;

  // Synchronous-read dual-port memory seen by the reader.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge rclk) if (mem_ren) mem_rdata <= mem[mem_raddr];

  int            n_checks = 0;
  int            n_fail   = 0;
  int            wcnt, popped;
  bit            pattern_mode;
  logic [DW-1:0] exp_q [$];
  int            addr_log [$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] gray_of(input int n);
    logic [PW-1:0] b;
    b = PW'(n);
    return b ^ (b >> 1);
  endfunction

  task automatic write_word();
    logic [DW-1:0] d;
    d = pattern_mode ? DW'(8'hA0 + (wcnt % DEPTH)) : DW'($urandom);
    mem[wcnt % DEPTH] = d;
    exp_q.push_back(d);
    wcnt++;
  endtask

  task automatic do_reset();
    rrst           = 1'b1;
    rd.rd_ready    = 1'b0;
    g_wptr_sync    = '0;
    repeat (2) @(negedge rclk);
    rrst   = 1'b0;
    wcnt   = 0;
    popped = 0;
    exp_q.delete();
    addr_log.delete();
  endtask

  // One rclk cycle: writer adds up to nwr words (never overrunning unread slots), consumer drives rdy.
  task automatic cycle(input logic rdy, input int nwr, input bit chk_lvl);
    int lvl;
    for (int k = 0; k < nwr; k++) if (wcnt - popped < DEPTH) write_word();
    g_wptr_sync = gray_of(wcnt);
    rd.rd_ready = rdy;
    #1;
    lvl = wcnt - popped;
    if (mem_ren) addr_log.push_back(int'(mem_raddr));
    if (rd.rd_valid && rdy) begin
      if (exp_q.size() == 0) check("pop_unexpected", 32'd1, 32'd0);
      else                   check("pop_data", 32'(rd.rd_data), 32'(exp_q.pop_front()));
      popped++;
    end
    @(negedge rclk);
    if (chk_lvl) begin
      check("rd_level", 32'(rd_level), 32'(lvl));
      check("almost_empty", 32'(almost_empty), 32'(lvl <= AE));
    end
  endtask

  initial begin
    int guard;
    rd.rd_ready = 1'b0;
    @(negedge rclk);

    // 1: idle after reset
    do_reset();
    repeat (5) @(negedge rclk);
    check("t1_ptr_empty", 32'(ptr_empty), 32'd1);
    check("t1_rd_valid", 32'(rd.rd_valid), 32'd0);
    check("t1_mem_ren", 32'(mem_ren), 32'd0);
    check("t1_rd_level", 32'(rd_level), 32'd0);
    check("t1_almost_empty", 32'(almost_empty), 32'd1);
    check("t1_rd_data", 32'(rd.rd_data), 32'd0);

    // 2: three words with consumer always ready; fetch-to-valid latency of two cycles
    pattern_mode = 1'b1;
    for (int i = 0; i < 3; i++) write_word();
    g_wptr_sync = gray_of(wcnt);
    rd.rd_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      check("t2_mem_ren", 32'(mem_ren), 32'(c < 3));
      if (c < 3) check("t2_mem_raddr", 32'(mem_raddr), 32'(c));
      check("t2_rd_valid", 32'(rd.rd_valid), 32'(c >= 2 && c < 5));
      if (c >= 2 && c < 5) check("t2_rd_data", 32'(rd.rd_data), 32'(8'hA0 + c - 2));
      @(negedge rclk);
    end
    check("t2_b_rptr", 32'(b_rptr), 32'd3);
    check("t2_ptr_empty", 32'(ptr_empty), 32'd1);

    // 3: eight words, consumer stalled: only two fetches, head stable, then full-rate drain
    do_reset();
    pattern_mode = 1'b1;
    cycle(1'b0, 8, 1'b1);
    for (int c = 1; c < 6; c++) begin
      cycle(1'b0, 0, 1'b1);
      if (c >= 2) begin
        check("t3_rd_valid", 32'(rd.rd_valid), 32'd1);
        check("t3_rd_data_hold", 32'(rd.rd_data), 32'hA0);
      end
    end
    check("t3_fetches", 32'(addr_log.size()), 32'd2);
    check("t3_level8", 32'(rd_level), 32'd8);
    for (int c = 0; c < 8; c++) cycle(1'b1, 0, 1'b1);
    check("t3_drain_rate", 32'(popped), 32'd8);
    check("t3_drained_valid", 32'(rd.rd_valid), 32'd0);
    check("t3_drained_empty", 32'(ptr_empty), 32'd1);

    // 4: pointer wrap with the writer ahead
    do_reset();
    pattern_mode = 1'b0;
    guard = 0;
    while (popped < 12 && guard < 200) begin
      cycle(1'b1, (wcnt < 12) ? 1 : 0, 1'b1);
      guard++;
    end
    check("t4_phaseA_done", 32'(popped), 32'd12);
    repeat (2) cycle(1'b1, 0, 1'b1);
    check("t4_addr_count", 32'(addr_log.size()), 32'd12);
    for (int i = 0; i < addr_log.size(); i++) check("t4_addr_seq", 32'(addr_log[i]), 32'(i % DEPTH));
    check("t4_b_rptr12", 32'(b_rptr), 32'b1100);
    check("t4_empty_at_12", 32'(ptr_empty), 32'd1);
    cycle(1'b0, 4, 1'b1);
    check("t4_wptr_wrapped_not_empty", 32'(ptr_empty), 32'd0);
    guard = 0;
    while (popped < 16 && guard < 100) begin
      cycle(1'b1, 0, 1'b1);
      guard++;
    end
    check("t4_phaseB_done", 32'(popped), 32'd16);
    cycle(1'b1, 0, 1'b1);
    check("t4_b_rptr_wrap", 32'(b_rptr), 32'd0);
    check("t4_g_rptr_wrap", 32'(g_rptr), 32'd0);
    check("t4_empty_equal", 32'(ptr_empty), 32'd1);
    for (int i = 12; i < 16 && i < addr_log.size(); i++)
      check("t4_addr_wrap", 32'(addr_log[i]), 32'(i % DEPTH));

    // 5: randomized producer and consumer
    do_reset();
    pattern_mode = 1'b0;
    guard = 0;
    while (popped < 50 && guard < 3000) begin
      cycle(1'($urandom_range(0, 1)), int'($urandom_range(0, 1)), 1'b1);
      guard++;
    end
    check("t5_words_out", 32'(popped >= 50), 32'd1);
    guard = 0;
    while (exp_q.size() != 0 && guard < 50) begin
      cycle(1'b1, 0, 1'b1);
      guard++;
    end
    check("t5_no_drops", 32'(exp_q.size()), 32'd0);
    check("t5_fetch_count", 32'(addr_log.size()), 32'(wcnt));
    check("t5_final_valid", 32'(rd.rd_valid), 32'd0);
    check("t5_final_empty", 32'(ptr_empty), 32'd1);

    // 6: reset while the output buffer holds two words
    do_reset();
    pattern_mode = 1'b1;
    cycle(1'b0, 8, 1'b0);
    repeat (3) cycle(1'b0, 0, 1'b0);
    check("t6_pre_valid", 32'(rd.rd_valid), 32'd1);
    check("t6_pre_data", 32'(rd.rd_data), 32'hA0);
    rrst = 1'b1;
    #1;
    check("t6_ren_in_reset", 32'(mem_ren), 32'd0);
    @(negedge rclk);
    check("t6_rd_valid", 32'(rd.rd_valid), 32'd0);
    check("t6_rd_data", 32'(rd.rd_data), 32'd0);
    check("t6_b_rptr", 32'(b_rptr), 32'd0);
    check("t6_g_rptr", 32'(g_rptr), 32'd0);
    check("t6_ren_held", 32'(mem_ren), 32'd0);
    @(negedge rclk);
    check("t6_ren_still_held", 32'(mem_ren), 32'd0);
    check("t6_level", 32'(rd_level), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
